// File: rtl/lia_pkg.sv
// Shared constants and the signed saturate helper for the lock-in boxcar averager.
package lia_pkg;

    localparam int unsigned LIA_DATA_W    = 24;
    localparam int unsigned LIA_OUT_W     = 16;
    localparam int unsigned LIA_MAX_LOG2  = 12;
    localparam int unsigned LIA_OUT_SHIFT = 4;
    localparam int unsigned LIA_LEN_W     = 5;
    localparam int unsigned LIA_ACC_W     = LIA_DATA_W + LIA_MAX_LOG2;

    localparam logic signed [LIA_OUT_W-1:0] LIA_OUT_MAX = {1'b0, {(LIA_OUT_W-1){1'b1}}};
    localparam logic signed [LIA_OUT_W-1:0] LIA_OUT_MIN = {1'b1, {(LIA_OUT_W-1){1'b0}}};

    typedef struct packed {
        logic                 sat;
        logic [LIA_OUT_W-1:0] val;
    } sat_res_t;

    // Clamp a wide signed value into the signed output range, flagging any clip.
    function automatic sat_res_t sat_to_out(input logic signed [LIA_ACC_W-1:0] v);
        sat_res_t r;
        r.sat = 1'b0;
        r.val = v[LIA_OUT_W-1:0];
        if (v > LIA_ACC_W'(LIA_OUT_MAX)) begin
            r.sat = 1'b1;
            r.val = LIA_OUT_MAX;
        end else if (v < LIA_ACC_W'(LIA_OUT_MIN)) begin
            r.sat = 1'b1;
            r.val = LIA_OUT_MIN;
        end
        return r;
    endfunction

endpackage

// File: rtl/lia_boxcar_chan.sv
// One boxcar channel: accumulator, stage-1 frame sum, and shift/saturate output stage.
module lia_boxcar_chan
    import lia_pkg::*;
#(
    parameter int unsigned DATA_W    = LIA_DATA_W,
    parameter int unsigned OUT_W     = LIA_OUT_W,
    parameter int unsigned MAX_LOG2  = LIA_MAX_LOG2,
    parameter int unsigned OUT_SHIFT = LIA_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_valid,
    input  logic                     i_clear,
    input  logic                     i_last,
    input  logic                     i_s1_vld,
    input  logic [LIA_LEN_W-1:0]     i_s1_len,
    output logic signed [OUT_W-1:0]  o_data,
    output logic                     o_sat_c
);

    localparam int unsigned ACC_W = DATA_W + MAX_LOG2;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_s1;
    logic signed [OUT_W-1:0] r_data;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shifted;
    sat_res_t                w_sat;

    assign w_sum     = r_acc + ACC_W'(i_data);
    // Arithmetic shift floors toward minus infinity, matching the averaging contract.
    assign w_shifted = r_s1 >>> (6'(i_s1_len) + 6'(OUT_SHIFT));
    assign w_sat     = sat_to_out(LIA_ACC_W'(w_shifted));
    assign o_sat_c   = w_sat.sat;
    assign o_data    = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_s1   <= '0;
            r_data <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_valid) begin
                r_acc <= i_last ? '0 : w_sum;
            end
            if (i_valid && !i_clear && i_last) begin
                r_s1 <= w_sum;
            end
            if (i_s1_vld) begin
                r_data <= OUT_W'(w_sat.val);
            end
        end
    end

endmodule

// File: rtl/lia_boxcar_decimator.sv
// Integrate-and-dump X/Y averager: frame counting, clear handling, output strobe and sticky saturation.
module lia_boxcar_decimator
    import lia_pkg::*;
#(
    parameter int unsigned DATA_W    = LIA_DATA_W,
    parameter int unsigned OUT_W     = LIA_OUT_W,
    parameter int unsigned MAX_LOG2  = LIA_MAX_LOG2,
    parameter int unsigned OUT_SHIFT = LIA_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_y,
    input  logic [LIA_LEN_W-1:0]     avg_log2,
    input  logic                     clear,
    output logic signed [OUT_W-1:0]  out_x,
    output logic signed [OUT_W-1:0]  out_y,
    output logic                     out_valid,
    output logic                     sat_flag
);

    localparam int unsigned CNT_W = MAX_LOG2;

    logic [CNT_W-1:0]     r_cnt;
    logic [LIA_LEN_W-1:0] r_len_q;
    logic [LIA_LEN_W-1:0] r_s1_len;
    logic                 r_fresh;
    logic                 r_s1_vld;
    logic                 r_out_valid;
    logic                 r_sat;

    logic [LIA_LEN_W-1:0] w_avg_cl;
    logic [LIA_LEN_W-1:0] w_len;
    logic [CNT_W-1:0]     w_mask;
    logic                 w_last;
    logic                 w_sat_x;
    logic                 w_sat_y;
    logic                 w_sat_evt;

    assign w_avg_cl = (avg_log2 > LIA_LEN_W'(MAX_LOG2)) ? LIA_LEN_W'(MAX_LOG2) : avg_log2;
    // Until the first cycle after reset has latched a length, use the live exponent.
    assign w_len     = r_fresh ? w_avg_cl : r_len_q;
    assign w_mask    = CNT_W'((32'd1 << w_len) - 32'd1);
    assign w_last    = in_valid && !clear && (r_cnt == w_mask);
    assign w_sat_evt = r_s1_vld && (w_sat_x || w_sat_y);

    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_len_q     <= '0;
            r_s1_len    <= '0;
            r_fresh     <= 1'b1;
            r_s1_vld    <= 1'b0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_s1_vld    <= w_last;
            r_out_valid <= r_s1_vld;
            if (w_last) begin
                r_s1_len <= w_len;
            end
            if (clear || w_last || r_fresh) begin
                r_len_q <= w_avg_cl;
                r_fresh <= 1'b0;
            end
            if (clear) begin
                r_cnt <= '0;
            end else if (in_valid) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            // A saturation landing in a clear cycle must still be reported.
            if (w_sat_evt) begin
                r_sat <= 1'b1;
            end else if (clear) begin
                r_sat <= 1'b0;
            end
        end
    end

    lia_boxcar_chan #(
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .MAX_LOG2  (MAX_LOG2),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_chan_x (
        .clk      (clk),
        .reset    (reset),
        .i_data   (in_x),
        .i_valid  (in_valid),
        .i_clear  (clear),
        .i_last   (w_last),
        .i_s1_vld (r_s1_vld),
        .i_s1_len (r_s1_len),
        .o_data   (out_x),
        .o_sat_c  (w_sat_x)
    );

    lia_boxcar_chan #(
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .MAX_LOG2  (MAX_LOG2),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_chan_y (
        .clk      (clk),
        .reset    (reset),
        .i_data   (in_y),
        .i_valid  (in_valid),
        .i_clear  (clear),
        .i_last   (w_last),
        .i_s1_vld (r_s1_vld),
        .i_s1_len (r_s1_len),
        .o_data   (out_y),
        .o_sat_c  (w_sat_y)
    );

endmodule

// File: tb/tb_lia_boxcar_decimator.sv
// Directed bench for the boxcar decimator with hand-computed frame averages.
module tb_lia_boxcar_decimator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [23:0] in_x;
    logic [23:0] in_y;
    logic [4:0]  avg_log2;
    logic        clear;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_valid;
    logic        sat_flag;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;

    lia_boxcar_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .avg_log2  (avg_log2),
        .clear     (clear),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_valid (out_valid),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) n_valid++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [23:0] x, input logic [23:0] y);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic restart(input logic [4:0] len);
        avg_log2 = len;
        clear    = 1'b1;
        tick(1);
        clear    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; clear = 1'b0; avg_log2 = 5'd2;
        #3;
        checks++; if (out_x !== 16'h0000 || out_y !== 16'h0000) begin errors++; $display("FAIL reset_out got x=%h y=%h want 0000 0000", out_x, out_y); end
        checks++; if (out_valid !== 1'b0 || sat_flag !== 1'b0) begin errors++; $display("FAIL reset_flags got valid=%b sat=%b want 0 0", out_valid, sat_flag); end
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_average;
        n_valid = 0;
        repeat (4) push(24'h001230, 24'hFFF000);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_early_valid got %b want 0", out_valid); end
        tick(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_valid got %b want 1", out_valid); end
        checks++; if (out_x !== 16'h0123 || out_y !== 16'hFF00) begin errors++; $display("FAIL avg_out got x=%h y=%h want 0123 FF00", out_x, out_y); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL avg_sat got %b want 0", sat_flag); end
        tick(2);
        checks++; if (n_valid != 1) begin errors++; $display("FAIL avg_pulse_count got %0d want 1", n_valid); end
    endtask

    task automatic test_saturation;
        restart(5'd1);
        repeat (2) push(24'h100000, 24'h800000);
        tick(1);
        checks++; if (out_x !== 16'h7FFF || out_y !== 16'h8000) begin errors++; $display("FAIL sat_out got x=%h y=%h want 7FFF 8000", out_x, out_y); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set got %b want 1", sat_flag); end
        repeat (2) push(24'h000100, 24'h000000);
        tick(1);
        checks++; if (out_x !== 16'h0010 || out_y !== 16'h0000) begin errors++; $display("FAIL sat_clean_out got x=%h y=%h want 0010 0000", out_x, out_y); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", sat_flag); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", sat_flag); end
        checks++; if (out_x !== 16'h0010) begin errors++; $display("FAIL sat_clear_hold got %h want 0010", out_x); end
    endtask

    task automatic test_gappy;
        restart(5'd3);
        n_valid = 0;
        for (int i = 0; i < 7; i++) begin
            push(24'h000160, 24'h000000);
            tick(2);
        end
        checks++; if (out_x !== 16'h0010 || n_valid != 0) begin errors++; $display("FAIL gap_hold got x=%h pulses=%0d want 0010 0", out_x, n_valid); end
        push(24'h000160, 24'h000000);
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'h0016) begin errors++; $display("FAIL gap_out got valid=%b x=%h want 1 0016", out_valid, out_x); end
        tick(4);
        checks++; if (n_valid != 1 || out_x !== 16'h0016) begin errors++; $display("FAIL gap_single got pulses=%0d x=%h want 1 0016", n_valid, out_x); end
    endtask

    task automatic test_clear;
        restart(5'd2);
        repeat (2) push(24'h7FFFF0, 24'h000000);
        in_valid = 1'b1; in_x = 24'h7FFFF0; clear = 1'b1;
        tick(1);
        in_valid = 1'b0; clear = 1'b0;
        n_valid = 0;
        repeat (3) push(24'h000100, 24'h000000);
        tick(3);
        checks++; if (n_valid != 0 || out_x !== 16'h0016) begin errors++; $display("FAIL clr_early got pulses=%0d x=%h want 0 0016", n_valid, out_x); end
        push(24'h000100, 24'h000000);
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'h0010) begin errors++; $display("FAIL clr_out got valid=%b x=%h want 1 0010", out_valid, out_x); end
    endtask

    task automatic test_back_to_back;
        restart(5'd2);
        push(24'h000400, 24'h000000);
        avg_log2 = 5'd0;
        n_valid = 0;
        repeat (2) push(24'h000400, 24'h000000);
        tick(2);
        checks++; if (n_valid != 0) begin errors++; $display("FAIL exp_midframe got pulses=%0d want 0", n_valid); end
        push(24'h000400, 24'h000000);
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'h0040) begin errors++; $display("FAIL exp_frame got valid=%b x=%h want 1 0040", out_valid, out_x); end
        push(24'hFFFFE0, 24'h000020);
        push(24'h000050, 24'hFFFFB0);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'hFFFE || out_y !== 16'h0002) begin errors++; $display("FAIL b2b_first got valid=%b x=%h y=%h want 1 FFFE 0002", out_valid, out_x, out_y); end
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'h0005 || out_y !== 16'hFFFB) begin errors++; $display("FAIL b2b_second got valid=%b x=%h y=%h want 1 0005 FFFB", out_valid, out_x, out_y); end
        tick(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midframe;
        restart(5'd0);
        avg_log2 = 5'd2;
        push(24'h7FFFF0, 24'h000000);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (sat_flag !== 1'b1 || out_valid !== 1'b1 || out_x !== 16'h7FFF) begin errors++; $display("FAIL set_over_clear got sat=%b valid=%b x=%h want 1 1 7FFF", sat_flag, out_valid, out_x); end
        repeat (3) push(24'h400000, 24'h400000);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_x !== 16'h0000 || out_y !== 16'h0000 || sat_flag !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_reset got x=%h y=%h sat=%b valid=%b want 0000 0000 0 0", out_x, out_y, sat_flag, out_valid); end
        tick(2);
        reset = 1'b0;
        repeat (4) push(24'h000200, 24'hFFFE00);
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'h0020 || out_y !== 16'hFFE0) begin errors++; $display("FAIL post_reset got valid=%b x=%h y=%h want 1 0020 FFE0", out_valid, out_x, out_y); end
    endtask

    task automatic test_clamp;
        restart(5'd31);
        n_valid = 0;
        for (int i = 0; i < 4095; i++) push(24'h000100, 24'h000000);
        tick(2);
        checks++; if (n_valid != 0) begin errors++; $display("FAIL clamp_early got pulses=%0d want 0", n_valid); end
        push(24'h000100, 24'h000000);
        tick(1);
        checks++; if (out_valid !== 1'b1 || out_x !== 16'h0010) begin errors++; $display("FAIL clamp_out got valid=%b x=%h want 1 0010", out_valid, out_x); end
    endtask

    initial begin
        test_reset();
        test_average();
        test_saturation();
        test_gappy();
        test_clear();
        test_back_to_back();
        test_reset_midframe();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lia_boxcar_decimator.md
Name: lia_boxcar_decimator

Overview:
- Integrate-and-dump boxcar averager for one lock-in channel pair (X and Y mixer products).
- Sums 2^avg_log2 signed samples, scales the sum, saturates it, and holds the result stable on 16-bit outputs.
- Sits between the mixer/low-pass chain and the 16-bit Avalon PIO input ports the CPU reads.
- Outputs change only at frame boundaries, so CPU reads of X and Y always come from the same frame.

Parameters:
- DATA_W, 24: signed input sample width.
- OUT_W, 16: signed output width (matches the PIO in_port width).
- MAX_LOG2, 12: largest allowed averaging exponent.
- OUT_SHIFT, 4: fixed extra right shift applied after averaging.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in_x/in_y for one cycle.
- in_x  in  DATA_W  signed X mixer sample.
- in_y  in  DATA_W  signed Y mixer sample.
- avg_log2  in  5  averaging exponent; frame length is 2^avg_log2 samples.
- clear  in  1  synchronous restart of the current frame.
- out_x  out  OUT_W  signed averaged X, held between frames.
- out_y  out  OUT_W  signed averaged Y, held between frames.
- out_valid  out  1  one-cycle pulse when out_x/out_y update.
- sat_flag  out  1  sticky flag: a saturation has occurred.

Behaviour:
- Clocking: one clock. Reset is asynchronous, active-high. Port names are clk and reset.
- Reset: out_x=0, out_y=0, out_valid=0, sat_flag=0. Accumulators, sample counter and pipeline are zeroed. Reset applies immediately, including mid-frame.
- Accumulators: acc_x and acc_y are signed, DATA_W+MAX_LOG2 bits wide, so they cannot overflow.
- Frame length: len_q is latched at frame start as min(avg_log2, MAX_LOG2).
- avg_log2 changes: take effect only at the next frame start, never mid-frame.
- Sample path: each in_valid cycle adds in_x/in_y to the accumulators and increments cnt. Cycles without in_valid hold all state, so gaps are allowed.
- Final sample: the in_valid cycle where cnt == 2^len_q - 1.
  - acc+in is loaded into pipeline stage-1 registers.
  - The accumulators and cnt restart at 0.
  - len_q reloads from avg_log2.
  - No sample is lost across the frame boundary.
- Stage 2, per channel:
  - Arithmetic right shift by len_q+OUT_SHIFT (truncation toward minus infinity).
  - Saturate to signed OUT_W: 0x7FFF or 0x8000 at default widths.
  - Register into out_x/out_y.
  - out_valid pulses high for one cycle.
  - Any saturation sets sat_flag.
- Latency: out_valid is asserted 2 cycles after the in_valid cycle of the final sample.
- avg_log2=0: every valid sample is its own frame. Output rate equals the valid rate; throughput is one result per cycle.
- clear:
  - Discards the partial frame (accumulators and cnt go to 0) and reloads len_q.
  - Clears sat_flag.
  - Does not alter out_x/out_y.
  - A stage-2 result already in flight still completes.
  - clear together with in_valid: clear wins, the sample is discarded.
- A saturation occurring in the same cycle as clear sets sat_flag (set wins over clear).
- avg_log2 > MAX_LOG2 is clamped to MAX_LOG2.

Decomposition:
- Shared package lia_pkg: default DATA_W/OUT_W/MAX_LOG2/OUT_SHIFT constants, and the signed saturate function (wide to OUT_W, returning value and saturation bit).
- One sub-module, lia_boxcar_chan: accumulator, stage-1 register and shift/saturate for a single channel. It is instantiated twice (X, Y).
- The top level owns cnt, len_q, clear handling, out_valid and sat_flag.

Test Plan:
- Averaging: avg_log2=2, four valid samples with in_x=0x001230 and in_y=0xFFF000 -> 2 cycles after the 4th sample, out_x=0x0123, out_y=0xFF00, out_valid high 1 cycle, sat_flag=0.
- Saturation: avg_log2=1, two samples with in_x=0x100000 and in_y=0x800000 -> out_x=0x7FFF, out_y=0x8000, sat_flag=1. sat_flag is still 1 after the next clean frame and returns to 0 after clear.
- Gappy input: avg_log2=3, eight samples of in_x=0x000160, in_valid every 3rd cycle -> exactly one out_valid, out_x=0x0016, outputs stable between frames.
- Clear mid-frame: avg_log2=2, two samples of 0x7FFFF0, then clear, then four samples of 0x000100 -> out_x=0x0010. No out_valid before the 4th post-clear sample. clear+in_valid in the same cycle drops that sample.
- Exponent change: avg_log2=2, one sample, then avg_log2 set to 0 -> the current frame still takes 4 samples. After that, each sample gives out_valid with out_x = in_x>>>4 (e.g. 0xFFFFE0 -> 0xFFFE).
- Reset mid-frame: assert reset after 3 of 4 samples -> outputs and sat_flag go to 0 asynchronously. After release, a fresh 4-sample frame gives the correct average, uncontaminated by the earlier samples.
